// File: rtl/hash_ctrl_fsm.sv
// hash_ctrl_fsm: sequences one hash job through RECEIVING -> HASHING -> SENDING,
// with ERROR entered when the host does not finish a transfer in time.
// Optional feature macro: HASH_CTRL_EARLY_EXIT_EN (leave HASHING as soon as a
// core reports a solution and record the lowest winning core index).
module hash_ctrl_fsm #(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned CNT_W        = 27,
  parameter int unsigned SEND_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic                 rx_done_i,
  input  logic                 tx_done_i,
  input  logic [CNT_W-1:0]     hash_cycles_i,
  input  logic [NUM_CORES-1:0] core_found_i,
  input  logic                 abort_i,
  output logic [NUM_CORES-1:0] hash_en_o,
  output logic                 write_en_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] winner_o,
  output logic                 winner_valid_o
);

  localparam int unsigned WIN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned TO_W  = (SEND_TIMEOUT > 1) ? $clog2(SEND_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_RECEIVING = 2'd0,
    ST_HASHING   = 2'd1,
    ST_SENDING   = 2'd2,
    ST_ERROR     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [WIN_W-1:0]     winner_q, winner_d;
  logic                 valid_q, valid_d;
  logic [NUM_CORES-1:0] hash_en_d;
  logic                 write_en_d, busy_d, timeout_d;

`ifdef HASH_CTRL_EARLY_EXIT_EN
  logic [WIN_W-1:0] first_idx;

  // Priority encoder: lowest set core_found bit wins.
  always_comb begin
    first_idx = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (core_found_i[i]) first_idx = WIN_W'(i);
    end
  end
`else
  logic unused_found;
  assign unused_found = ^core_found_i;
`endif

  // Next-state, counter and output decode; outputs follow the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    winner_d   = winner_q;
    valid_d    = valid_q;
    hash_en_d  = '0;
    write_en_d = 1'b0;
    busy_d     = 1'b0;
    timeout_d  = 1'b0;

    if (abort_i) begin
      state_d = ST_RECEIVING;
      cnt_d   = '0;
      to_d    = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RECEIVING: begin
          if (rx_done_i) begin
            state_d = ST_HASHING;
            cnt_d   = hash_cycles_i;
            valid_d = 1'b0;
          end
        end
        ST_HASHING: begin
          if (cnt_q == '0) begin
            state_d = ST_SENDING;
            to_d    = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
`ifdef HASH_CTRL_EARLY_EXIT_EN
          if (|core_found_i) begin
            state_d  = ST_SENDING;
            cnt_d    = '0;
            to_d     = '0;
            winner_d = first_idx;
            valid_d  = 1'b1;
          end
`endif
        end
        ST_SENDING: begin
          // tx_done wins over a simultaneous timeout expiry.
          if (tx_done_i) begin
            state_d = ST_RECEIVING;
            to_d    = '0;
          end else if (to_q == TO_W'(SEND_TIMEOUT - 1)) begin
            state_d = ST_ERROR;
            to_d    = '0;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_RECEIVING;
          cnt_d   = '0;
          to_d    = '0;
          valid_d = 1'b0;
        end
      endcase
    end

    hash_en_d  = (state_d == ST_HASHING) ? {NUM_CORES{1'b1}} : '0;
    write_en_d = (state_d == ST_SENDING);
    busy_d     = (state_d != ST_RECEIVING);
    timeout_d  = (state_d == ST_ERROR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_RECEIVING;
      cnt_q          <= '0;
      to_q           <= '0;
      winner_q       <= '0;
      valid_q        <= 1'b0;
      hash_en_o      <= '0;
      write_en_o     <= 1'b0;
      busy_o         <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_q           <= to_d;
      winner_q       <= winner_d;
      valid_q        <= valid_d;
      hash_en_o      <= hash_en_d;
      write_en_o     <= write_en_d;
      busy_o         <= busy_d;
      timeout_o      <= timeout_d;
    end
  end

  assign winner_o       = winner_q;
  assign winner_valid_o = valid_q;

endmodule

// File: tb/tb_hash_ctrl_fsm.sv
// Self-checking bench for hash_ctrl_fsm (NUM_CORES=4, SEND_TIMEOUT=8).
module tb_hash_ctrl_fsm;

  localparam int unsigned NUM_CORES    = 4;
  localparam int unsigned CNT_W        = 27;
  localparam int unsigned SEND_TIMEOUT = 8;
`ifdef HASH_CTRL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 rx_done = 1'b0;
  logic                 tx_done = 1'b0;
  logic [CNT_W-1:0]     hash_cycles = '0;
  logic [NUM_CORES-1:0] core_found = '0;
  logic                 abort = 1'b0;
  logic [NUM_CORES-1:0] hash_en_o;
  logic                 write_en_o, busy_o, timeout_o, winner_valid_o;
  logic [1:0]           winner_o;

  int errors = 0;
  int checks = 0;

  hash_ctrl_fsm #(
    .NUM_CORES(NUM_CORES), .CNT_W(CNT_W), .SEND_TIMEOUT(SEND_TIMEOUT)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .rx_done_i(rx_done), .tx_done_i(tx_done),
    .hash_cycles_i(hash_cycles), .core_found_i(core_found), .abort_i(abort),
    .hash_en_o(hash_en_o), .write_en_o(write_en_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .winner_o(winner_o), .winner_valid_o(winner_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hash_en"},  32'(hash_en_o), 32'd0);
    check({tag, "_write_en"}, 32'(write_en_o), 32'd0);
    check({tag, "_busy"},     32'(busy_o), 32'd0);
    check({tag, "_timeout"},  32'(timeout_o), 32'd0);
  endtask

  // One job: budget, tx_done on SENDING cycle tx_at (0 = never),
  // fvec presented on HASHING cycle fcyc (0 = never).
  task automatic run_txn(input int budget, input int tx_at, input int fcyc,
                         input logic [3:0] fvec);
    int n, m, exp_h, exp_s, widx, v;
    bit hit;
    hit   = EARLY && fcyc != 0 && fcyc <= budget + 1 && fvec != 4'd0;
    exp_h = hit ? fcyc : budget + 1;
    v     = int'(fvec);
    widx  = (v == 0) ? 0 : $clog2(v & -v);
    exp_s = (tx_at >= 1 && tx_at <= int'(SEND_TIMEOUT)) ? tx_at : int'(SEND_TIMEOUT);

    rx_done = 1'b1;
    hash_cycles = CNT_W'(budget);
    @(negedge clk);
    rx_done = 1'b0;
    n = 0;
    while (hash_en_o == 4'hF && n < budget + 10) begin
      n++;
      tx_done    = $urandom_range(0, 1) == 1;  // ignored outside SENDING
      core_found = (n == fcyc) ? fvec : 4'd0;
      @(negedge clk);
    end
    core_found = 4'd0;
    tx_done    = 1'b0;
    check("hash_len", 32'(n), 32'(exp_h));
    check("send_entry", 32'(write_en_o), 32'd1);
    check("send_busy", 32'(busy_o), 32'd1);
    check("winner_valid", 32'(winner_valid_o), 32'(hit));
    if (hit || !EARLY) check("winner", 32'(winner_o), hit ? 32'(widx) : 32'd0);

    m = 0;
    while (write_en_o && m < 20) begin
      m++;
      tx_done = (m == tx_at);
      rx_done = $urandom_range(0, 1) == 1;   // ignored outside RECEIVING
      @(negedge clk);
    end
    tx_done = 1'b0;
    rx_done = 1'b0;
    check("send_len", 32'(m), 32'(exp_s));
    check("timeout", 32'(timeout_o), 32'(tx_at == 0));
    check("busy_after_send", 32'(busy_o), 32'(tx_at == 0));
    if (tx_at == 0) begin
      rx_done = 1'b1;
      tx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      tx_done = 1'b0;
      check("err_hold", 32'(timeout_o), 32'd1);
      check("err_write_en", 32'(write_en_o), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle("abort_err");
      check("abort_valid", 32'(winner_valid_o), 32'd0);
    end else begin
      check("valid_keep", 32'(winner_valid_o), 32'(hit));
    end
  endtask

  initial begin
    int b, t, f;
    logic [3:0] fv;

    // Reset state with clock running
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_valid", 32'(winner_valid_o), 32'd0);
    check("reset_winner", 32'(winner_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Budget 5 -> 6 hashing cycles, tx_done on 3rd sending cycle
    run_txn(5, 3, 0, 4'd0);
    // Budget 0 -> 1 hashing cycle
    run_txn(0, 1, 0, 4'd0);
    // No tx_done -> ERROR after 8 sending cycles, then abort
    run_txn(2, 0, 0, 4'd0);
    // tx_done on the 8th sending cycle wins over expiry
    run_txn(1, 8, 0, 4'd0);
    // Found on hashing cycle 3 with budget 100
    run_txn(100, 2, 3, 4'b0110);

    // Abort mid-HASHING
    rx_done = 1'b1;
    hash_cycles = CNT_W'(30);
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
    check("abort_pre_hash", 32'(hash_en_o), 32'hF);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_hash");

    // Randomized jobs
    for (int k = 0; k < 12; k++) begin
      b  = int'($urandom_range(0, 20));
      t  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 8));
      f  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 24));
      fv = 4'($urandom_range(1, 15));
      run_txn(b, t, f, fv);
    end

    // Asynchronous reset mid-HASHING
    rx_done = 1'b1;
    hash_cycles = CNT_W'(50);
    @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_hash", 32'(hash_en_o), 32'hF);
    #1 rst_ni = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_valid", 32'(winner_valid_o), 32'd0);
    check("async_rst_winner", 32'(winner_o), 32'd0);
    @(negedge clk);
    rst_ni  = 1'b1;
    rx_done = 1'b1;
    hash_cycles = CNT_W'(0);
    #1;
    check("rst_release_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rx_done = 1'b0;
    check("first_edge_hash", 32'(hash_en_o), 32'hF);
    @(negedge clk);
    check("first_edge_send", 32'(write_en_o), 32'd1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hash_ctrl_fsm.md
HASH_CTRL_FSM -- requirements
Module: hash_ctrl_fsm

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4: number of hash cores driven, range 1..16.
REQ-002 The block SHALL have parameter CNT_W, default 27: width of the hash-budget counter.
REQ-003 The block SHALL have parameter SEND_TIMEOUT, default 1024: cycles allowed in SENDING before an error, minimum 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port rx_done_i, input, 1 bit: host payload fully received.
REQ-007 The block SHALL have port tx_done_i, input, 1 bit: result fully sent to host.
REQ-008 The block SHALL have port hash_cycles_i, input, CNT_W bits: hash budget, sampled on entry to HASHING.
REQ-009 The block SHALL have port core_found_i, input, NUM_CORES bits: per-core solution-found flag.
REQ-010 The block SHALL have port abort_i, input, 1 bit: software abort or error clear.
REQ-011 The block SHALL have port hash_en_o, output, NUM_CORES bits: per-core hash enable.
REQ-012 The block SHALL have port write_en_o, output, 1 bit: transmit path enable.
REQ-013 The block SHALL have port busy_o, output, 1 bit: state is not RECEIVING.
REQ-014 The block SHALL have port timeout_o, output, 1 bit: high while in ERROR.
REQ-015 The block SHALL have port winner_o, output, clog2(NUM_CORES) bits (minimum 1): index of the winning core.
REQ-016 The block SHALL have port winner_valid_o, output, 1 bit: winner_o holds a valid index.

Function
REQ-017 The block SHALL implement a registered Moore FSM with the states RECEIVING, HASHING, SENDING and ERROR; all outputs are decoded from registered state only.
REQ-018 In RECEIVING, rx_done_i=1 SHALL cause a move to HASHING on the next edge, load the budget counter with hash_cycles_i, and clear winner_valid_o.
REQ-019 In HASHING, hash_en_o SHALL be all ones; each cycle, if the counter is 0 the FSM moves to SENDING, otherwise the counter decrements.
REQ-020 HASHING SHALL last hash_cycles_i+1 cycles; hash_cycles_i=0 gives exactly 1 cycle; there is no wrap-around.
REQ-021 In SENDING, write_en_o SHALL be 1 and the timeout counter (reset to 0 on entry) increments each cycle.
REQ-022 In SENDING, tx_done_i=1 SHALL cause a move to RECEIVING.
REQ-023 In SENDING, reaching SEND_TIMEOUT-1 without tx_done_i SHALL cause a move to ERROR.
REQ-024 If tx_done_i and timeout expiry occur in the same cycle, tx_done_i SHALL win.
REQ-025 ERROR SHALL hold with timeout_o=1 and write_en_o=0 until abort_i.
REQ-026 abort_i SHALL have the highest priority: from any state the next state is RECEIVING, the counters clear and winner_valid_o clears.
REQ-027 Outside RECEIVING, rx_done_i SHALL be ignored; outside SENDING, tx_done_i SHALL be ignored.
REQ-028 hash_en_o SHALL be 0 and write_en_o SHALL be 0 in every state where REQ-019 and REQ-021 do not assert them.
REQ-029 The block SHALL never encode an illegal state; any unused encoding transitions to RECEIVING.

Reset
REQ-030 While rst_ni=0, the block SHALL asynchronously set state=RECEIVING, both counters to 0, hash_en_o=0, write_en_o=0, busy_o=0, timeout_o=0, winner_o=0 and winner_valid_o=0.
REQ-031 Reset asserted mid-HASHING or mid-SENDING SHALL drop the enables immediately, without waiting for a clock edge.
REQ-032 The first state update after reset deassertion SHALL occur on the next rising edge of clk.

Configuration
REQ-033 With HASH_CTRL_EARLY_EXIT_EN defined, any core_found_i bit set in HASHING SHALL force a move to SENDING on the next edge, latch winner_o as the lowest set index, and set winner_valid_o=1 until the next RECEIVING exit or abort.
REQ-034 Without HASH_CTRL_EARLY_EXIT_EN, core_found_i SHALL be ignored, winner_o SHALL be 0 and winner_valid_o SHALL be 0, and HASHING SHALL always run the full budget.

Verification
REQ-035 The bench SHALL cover: rx_done_i pulse with hash_cycles_i=5 -> hash_en_o=4'hF for exactly 6 cycles, then write_en_o=1.
REQ-036 The bench SHALL cover: hash_cycles_i=0 -> exactly 1 HASHING cycle, then SENDING.
REQ-037 The bench SHALL cover: SEND_TIMEOUT=8 with no tx_done_i -> ERROR after 8 SENDING cycles, timeout_o=1, write_en_o=0; then abort_i -> RECEIVING, busy_o=0.
REQ-038 The bench SHALL cover: tx_done_i coinciding with the 8th SENDING cycle -> RECEIVING, timeout_o stays 0.
REQ-039 The bench SHALL cover, with EARLY_EXIT_EN: core_found_i=4'b0110 on HASHING cycle 3 with budget 100 -> SENDING on the next edge, winner_o=1, winner_valid_o=1; without the macro -> the full 101 cycles, winner_valid_o=0.
REQ-040 The bench SHALL cover: rst_ni=0 asynchronously mid-HASHING -> hash_en_o=0 before the next edge, with all outputs at their reset values.
